// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback has priority, and long-latency results queue in a FIFO.
// Optional macro WB_ARB_STARVE_EN adds a wait counter that requests a bubble when the FIFO head is starved.
module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic                     cpu_clk_50M,
  input  logic                     cpu_rst,
  input  logic                     wb_wreg_i,
  input  logic [4:0]               wb_wa_i,
  input  logic [31:0]              wb_wd_i,
  input  logic                     lu_valid_i,
  input  logic [4:0]               lu_wa_i,
  input  logic [31:0]              lu_wd_i,
  output logic                     lu_ready_o,
  input  logic                     id_re1_i,
  input  logic                     id_re2_i,
  input  logic [4:0]               id_ra1_i,
  input  logic [4:0]               id_ra2_i,
  input  logic                     id_wreg_i,
  input  logic [4:0]               id_wa_i,
  output logic                     rf_we_o,
  output logic [4:0]               rf_wa_o,
  output logic [31:0]              rf_wd_o,
  output logic                     hazard_stall_o,
  output logic                     starve_stall_o,
  output logic [$clog2(DEPTH):0]   pend_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;

  ent_t             mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push, store, wb_win, pop;

  assign lu_ready_o = !cpu_rst && (cnt_q < CW'(DEPTH));
  assign push       = lu_valid_i && lu_ready_o;
  // r0 results complete the handshake but are never queued
  assign store      = push && (lu_wa_i != 5'd0);
  assign wb_win     = wb_wreg_i && (wb_wa_i != 5'd0);
  assign pop        = !cpu_rst && !wb_win && (cnt_q != '0);
  assign pend_cnt_o = cnt_q;

  always_comb begin
    rf_we_o = 1'b0;
    rf_wa_o = 5'd0;
    rf_wd_o = 32'd0;
    if (!cpu_rst) begin
      if (wb_win) begin
        rf_we_o = 1'b1;
        rf_wa_o = wb_wa_i;
        rf_wd_o = wb_wd_i;
      end else if (pop) begin
        rf_we_o = 1'b1;
        rf_wa_o = mem_q[rd_ptr_q].wa;
        rf_wd_o = mem_q[rd_ptr_q].wd;
      end
    end
  end

  // The head stays visible to the hazard check in the cycle it is popped
  always_comb begin
    hazard_stall_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!cpu_rst && vld_q[i] && (mem_q[i].wa != 5'd0) &&
          ((id_re1_i  && (id_ra1_i == mem_q[i].wa)) ||
           (id_re2_i  && (id_ra2_i == mem_q[i].wa)) ||
           (id_wreg_i && (id_wa_i  == mem_q[i].wa))))
        hazard_stall_o = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (store && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!store && pop) cnt_d = cnt_q - CW'(1);
    vld_d = vld_q;
    if (pop)   vld_d[rd_ptr_q] = 1'b0;
    if (store) vld_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      cnt_q    <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      if (store) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (store) mem_q[wr_ptr_q] <= '{wa: lu_wa_i, wd: lu_wd_i};
  end

`ifdef WB_ARB_STARVE_EN
  logic [7:0] wait_q, wait_d;

  always_comb begin
    wait_d = wait_q;
    if (pop || (cnt_q == '0))          wait_d = 8'd0;
    else if (wait_q != 8'(STARVE_MAX)) wait_d = wait_q + 8'd1;
  end

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) wait_q <= 8'd0;
    else         wait_q <= wait_d;
  end

  assign starve_stall_o = (wait_q == 8'(STARVE_MAX));
`else
  assign starve_stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a per-cycle vector table plus starvation and async-reset sequences.
module tb_wb_port_arbiter;
`ifdef WB_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif
  localparam int NV = 23;

  logic        clk, rst;
  logic        wb_wreg, lu_valid, lu_ready, re1, re2, id_wreg;
  logic [4:0]  wb_wa, lu_wa, ra1, ra2, id_wa, rf_wa;
  logic [31:0] wb_wd, lu_wd, rf_wd;
  logic        rf_we, hz, starve;
  logic [1:0]  pend;
  int          checks = 0, errors = 0;

  wb_port_arbiter #(.DEPTH(2), .STARVE_MAX(8)) dut (
    .cpu_clk_50M(clk), .cpu_rst(rst),
    .wb_wreg_i(wb_wreg), .wb_wa_i(wb_wa), .wb_wd_i(wb_wd),
    .lu_valid_i(lu_valid), .lu_wa_i(lu_wa), .lu_wd_i(lu_wd), .lu_ready_o(lu_ready),
    .id_re1_i(re1), .id_re2_i(re2), .id_ra1_i(ra1), .id_ra2_i(ra2),
    .id_wreg_i(id_wreg), .id_wa_i(id_wa),
    .rf_we_o(rf_we), .rf_wa_o(rf_wa), .rf_wd_o(rf_wd),
    .hazard_stall_o(hz), .starve_stall_o(starve), .pend_cnt_o(pend)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        wbw;  logic [4:0] wbwa; logic [31:0] wbwd;
    logic        luv;  logic [4:0] luwa; logic [31:0] luwd;
    logic        re1;  logic [4:0] ra1;  logic re2; logic [4:0] ra2;
    logic        idw;  logic [4:0] idwa;
    logic        we;   logic [4:0] ewa;  logic [31:0] ewd;
    logic        rdy;  logic hz; logic [1:0] cnt;
  } vec_t;

  vec_t  tbl [NV];
  string nm  [NV];

  function automatic vec_t mk(logic wbw, logic [4:0] wbwa, logic [31:0] wbwd,
                              logic luv, logic [4:0] luwa, logic [31:0] luwd,
                              logic r1, logic [4:0] a1, logic r2, logic [4:0] a2,
                              logic iw, logic [4:0] iwa,
                              logic we, logic [4:0] ewa, logic [31:0] ewd,
                              logic rdy, logic h, logic [1:0] cnt);
    vec_t v;
    v.wbw = wbw; v.wbwa = wbwa; v.wbwd = wbwd;
    v.luv = luv; v.luwa = luwa; v.luwd = luwd;
    v.re1 = r1;  v.ra1 = a1;    v.re2 = r2; v.ra2 = a2;
    v.idw = iw;  v.idwa = iwa;
    v.we = we;   v.ewa = ewa;   v.ewd = ewd;
    v.rdy = rdy; v.hz = h;      v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [63:0] outs();
    return {21'd0, rf_we, rf_wa, rf_wd, lu_ready, hz, pend, starve};
  endfunction

  function automatic logic [63:0] pack(logic we, logic [4:0] wa, logic [31:0] wd,
                                       logic rdy, logic h, logic [1:0] cnt, logic st);
    return {21'd0, we, wa, wd, rdy, h, cnt, st};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wb_wreg = 0; wb_wa = 0; wb_wd = 0;
    lu_valid = 0; lu_wa = 0; lu_wd = 0;
    re1 = 0; ra1 = 0; re2 = 0; ra2 = 0; id_wreg = 0; id_wa = 0;
  endtask

  task automatic drive(input vec_t v);
    wb_wreg = v.wbw; wb_wa = v.wbwa; wb_wd = v.wbwd;
    lu_valid = v.luv; lu_wa = v.luwa; lu_wd = v.luwd;
    re1 = v.re1; ra1 = v.ra1; re2 = v.re2; ra2 = v.ra2;
    id_wreg = v.idw; id_wa = v.idwa;
  endtask

  initial begin
    //                   wb            lu                re1 ra1 re2 ra2 idw idwa  we wa wd           rdy hz cnt
    nm[0]  = "idle";      tbl[0]  = mk(0,0,0,       0,0,0,           0,0, 0,0,  0,0,  0,0,0,         1,0,0);
    nm[1]  = "push5";     tbl[1]  = mk(0,0,0,       1,5,32'h1234,    0,0, 0,0,  0,0,  0,0,0,         1,0,0);
    nm[2]  = "pop5";      tbl[2]  = mk(0,0,0,       0,0,0,           0,0, 0,0,  0,0,  1,5,32'h1234,  1,0,1);
    nm[3]  = "empty";     tbl[3]  = mk(0,0,0,       0,0,0,           0,0, 0,0,  0,0,  0,0,0,         1,0,0);
    nm[4]  = "wb_pass";   tbl[4]  = mk(1,3,32'hAAAA,0,0,0,           0,0, 0,0,  0,0,  1,3,32'hAAAA,  1,0,0);
    nm[5]  = "wb_r0";     tbl[5]  = mk(1,0,32'h5555,0,0,0,           0,0, 0,0,  0,0,  0,0,0,         1,0,0);
    nm[6]  = "push_r0";   tbl[6]  = mk(0,0,0,       1,0,32'hDEAD,    0,0, 0,0,  0,0,  0,0,0,         1,0,0);
    nm[7]  = "r0_drop";   tbl[7]  = mk(0,0,0,       0,0,0,           0,0, 0,0,  0,0,  0,0,0,         1,0,0);
    nm[8]  = "push9";     tbl[8]  = mk(1,3,1,       1,9,32'h9999,    0,0, 0,0,  0,0,  1,3,1,         1,0,0);
    nm[9]  = "push10";    tbl[9]  = mk(1,3,2,       1,10,32'hA0A0,   0,9, 0,0,  0,0,  1,3,2,         1,0,1);
    nm[10] = "full_raw1"; tbl[10] = mk(1,3,3,       1,11,32'hBBBB,   1,10,0,0,  0,0,  1,3,3,         0,1,2);
    nm[11] = "waw";       tbl[11] = mk(1,3,4,       0,0,0,           0,0, 0,0,  1,9,  1,3,4,         0,1,2);
    nm[12] = "raw2_miss"; tbl[12] = mk(1,3,5,       0,0,0,           0,0, 1,12, 0,0,  1,3,5,         0,0,2);
    nm[13] = "raw2_hit";  tbl[13] = mk(1,3,6,       0,0,0,           0,0, 1,9,  0,0,  1,3,6,         0,1,2);
    nm[14] = "pop9_full"; tbl[14] = mk(0,0,0,       0,0,0,           1,9, 0,0,  0,0,  1,9,32'h9999,  0,1,2);
    nm[15] = "pop10";     tbl[15] = mk(0,0,0,       0,0,0,           0,0, 0,0,  0,0,  1,10,32'hA0A0, 1,0,1);
    nm[16] = "drained";   tbl[16] = mk(0,0,0,       0,0,0,           0,0, 0,0,  0,0,  0,0,0,         1,0,0);
    nm[17] = "push4";     tbl[17] = mk(0,0,0,       1,4,32'h44,      0,0, 0,0,  0,0,  0,0,0,         1,0,0);
    nm[18] = "push6_wb";  tbl[18] = mk(1,3,7,       1,6,32'h66,      0,0, 0,0,  0,0,  1,3,7,         1,0,1);
    nm[19] = "pop4";      tbl[19] = mk(0,0,0,       0,0,0,           0,0, 0,0,  0,0,  1,4,32'h44,    0,0,2);
    nm[20] = "push_pop";  tbl[20] = mk(0,0,0,       1,8,32'h88,      0,0, 0,0,  0,0,  1,6,32'h66,    1,0,1);
    nm[21] = "pop8";      tbl[21] = mk(0,0,0,       0,0,0,           0,0, 0,0,  0,0,  1,8,32'h88,    1,0,1);
    nm[22] = "final";     tbl[22] = mk(0,0,0,       0,0,0,           0,0, 0,0,  0,0,  0,0,0,         1,0,0);

    // Reset with a live writeback request: every output must still read 0
    rst = 1'b1;
    idle_inputs();
    wb_wreg = 1; wb_wa = 5'd3; wb_wd = 32'h77;
    #3 chk("reset_outs", outs(), pack(0,0,0,0,0,0,0));
    @(negedge clk);
    chk("reset_hold", outs(), pack(0,0,0,0,0,0,0));
    #2 rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("after_release", outs(), pack(0,0,0,1,0,0,0));
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk(nm[i], outs(), pack(tbl[i].we, tbl[i].ewa, tbl[i].ewd,
                              tbl[i].rdy, tbl[i].hz, tbl[i].cnt, 1'b0));
      @(posedge clk); #1;
    end

    // Starvation: r7 held behind a busy writeback
    idle_inputs();
    wb_wreg = 1; wb_wa = 5'd3; wb_wd = 32'h33;
    lu_valid = 1; lu_wa = 5'd7; lu_wd = 32'h77;
    @(posedge clk); #1;
    lu_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("starve_wait%0d", i), outs(),
          pack(1, 3, 32'h33, 1, 0, 1, STARVE_EN && (i >= 8)));
      @(posedge clk); #1;
    end
    wb_wreg = 0;
    @(negedge clk);
    chk("starve_pop7", outs(), pack(1, 7, 32'h77, 1, 0, 1, STARVE_EN));
    @(posedge clk); #1;
    @(negedge clk);
    chk("starve_drop", outs(), pack(0, 0, 0, 1, 0, 0, 0));
    @(posedge clk); #1;

    // Async reset mid-cycle with two pending entries
    wb_wreg = 1; wb_wa = 5'd3; wb_wd = 32'h1;
    lu_valid = 1; lu_wa = 5'd12; lu_wd = 32'hC;
    @(posedge clk); #1;
    lu_wa = 5'd13; lu_wd = 32'hD;
    @(posedge clk); #1;
    lu_valid = 0; re1 = 1; ra1 = 5'd12;
    #2 chk("pre_reset", outs(), pack(1, 3, 32'h1, 0, 1, 2, 0));
    rst = 1'b1;
    #1 chk("async_reset", outs(), pack(0,0,0,0,0,0,0));
    @(negedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_reset%0d", i), outs(), pack(0,0,0,1,0,0,0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
